bus_cycle_ctrl: RTL and testbench

- Parametrised 68000 bus-cycle controller. Successor to the fixed-map glue decoder and the separate bus-error logic in the CPLD top level.
- Decodes up to NREG address regions into even/odd chip selects.
- Generates DTACK internally, with a per-region wait-state count, or forwards an external DTACK.
- Asserts BERR when a cycle is unmapped or an external-acknowledge cycle times out.
- Sits between the CPU bus pins and the memory/peripheral chip selects.

---
 rtl/bus_cycle_ctrl.sv | 177 +++++++++++++++++
 tb/tb_bus_cycle_ctrl.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/bus_cycle_ctrl.sv
// 68000 bus-cycle controller: region decode to even/odd chip selects, internal
// wait-state or external DTACK generation, and BERR on unmapped/timed-out cycles.
module bus_cycle_ctrl #(
  parameter int unsigned              ADDR_W   = 24,
  parameter int unsigned              NREG     = 4,
  parameter logic [NREG*ADDR_W-1:0]   REG_BASE = '0,
  parameter logic [NREG*ADDR_W-1:0]   REG_MASK = '0,
  parameter int unsigned              WAIT_W   = 4,
  parameter logic [NREG*WAIT_W-1:0]   REG_WAIT = '0,
  parameter logic [NREG-1:0]          REG_EXT  = '0,
  parameter int unsigned              TIMEOUT  = 64,
  parameter int unsigned              TO_W     = 7
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] addr,
  input  logic              as_n,
  input  logic              uds_n,
  input  logic              lds_n,
  input  logic              ext_dtack_n,
  output logic [NREG-1:0]   cs_evn_n,
  output logic [NREG-1:0]   cs_odd_n,
  output logic              dtack_n,
  output logic              berr_n,
  output logic              cycle_busy,
  output logic [2:0]        region
);

  localparam int unsigned RGN_W = 3;
  localparam logic [ADDR_W-1:0] CMP_MASK = ~ADDR_W'(1);
  localparam logic [TO_W-1:0]   TO_LAST  = TO_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_WAIT, S_EXTW, S_UNMAP, S_ACK, S_BERR
  } state_t;

  state_t            state_q, state_d;
  logic [WAIT_W-1:0] wcnt_q, wcnt_d;
  logic [TO_W-1:0]   tcnt_q, tcnt_d, tcnt_inc;
  logic [RGN_W-1:0]  region_d;
  logic              armed_q, armed_d;
  logic [NREG-1:0]   cs_evn_d, cs_odd_d;
  logic              dtack_d, berr_d, busy_d;

  logic [NREG-1:0]   match;
  logic              hit;
  logic [RGN_W-1:0]  hit_idx;
  logic [WAIT_W-1:0] hit_wait;
  logic              hit_ext;

  // Region decode; lowest matching index wins
  always_comb begin
    match    = '0;
    hit      = 1'b0;
    hit_idx  = '0;
    hit_wait = '0;
    hit_ext  = 1'b0;
    for (int r = 0; r < int'(NREG); r++) begin
      match[r] = (((addr ^ REG_BASE[r*ADDR_W +: ADDR_W]) & REG_MASK[r*ADDR_W +: ADDR_W]
                   & CMP_MASK) == '0);
      if (match[r] && !hit) begin
        hit      = 1'b1;
        hit_idx  = RGN_W'(r);
        hit_wait = REG_WAIT[r*WAIT_W +: WAIT_W];
        hit_ext  = REG_EXT[r];
      end
    end
  end

  // Next state and registered-output values
  always_comb begin
    state_d  = state_q;
    wcnt_d   = wcnt_q;
    tcnt_d   = tcnt_q;
    region_d = region;
    armed_d  = armed_q;
    cs_evn_d = '1;
    cs_odd_d = '1;
    dtack_d  = 1'b1;
    berr_d   = 1'b1;
    tcnt_inc = (tcnt_q == '1) ? tcnt_q : tcnt_q + TO_W'(1);

    case (state_q)
      S_IDLE: begin
        if (as_n) begin
          armed_d = 1'b1;
        end else if (armed_q) begin
          armed_d = 1'b0;
          tcnt_d  = '0;
          if (hit) begin
            region_d = hit_idx;
            wcnt_d   = hit_wait;
            if (hit_ext)              state_d = S_EXTW;
            else if (hit_wait == '0)  state_d = S_ACK;
            else                      state_d = S_WAIT;
          end else begin
            region_d = '0;
            state_d  = S_UNMAP;
          end
        end
      end
      S_WAIT: begin
        if (as_n) begin
          state_d = S_IDLE;
        end else begin
          wcnt_d = (wcnt_q == '0) ? wcnt_q : wcnt_q - WAIT_W'(1);
          if (wcnt_q <= WAIT_W'(1)) state_d = S_ACK;
        end
      end
      S_EXTW: begin
        if (as_n) begin
          state_d = S_IDLE;
        end else begin
          tcnt_d = tcnt_inc;
          if (!ext_dtack_n)              state_d = S_ACK;
          else if (tcnt_inc >= TO_LAST)  state_d = S_BERR;
        end
      end
      S_UNMAP: begin
        if (as_n) begin
          state_d = S_IDLE;
        end else begin
          tcnt_d = tcnt_inc;
          if (tcnt_inc >= TO_LAST) state_d = S_BERR;
        end
      end
      S_ACK: begin
        if (as_n) state_d = S_IDLE;
        else      dtack_d = 1'b0;
      end
      S_BERR: begin
        if (as_n) state_d = S_IDLE;
        else      berr_d  = 1'b0;
      end
      default: state_d = S_IDLE;
    endcase

    // Strobes follow uds_n/lds_n every clock while the latched region is selected
    if (!as_n && (state_q == S_WAIT || state_q == S_EXTW || state_q == S_ACK)) begin
      for (int r = 0; r < int'(NREG); r++) begin
        if (RGN_W'(r) == region) begin
          cs_evn_d[r] = uds_n;
          cs_odd_d[r] = lds_n;
        end
      end
    end

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      wcnt_q     <= '0;
      tcnt_q     <= '0;
      armed_q    <= 1'b0;
      region     <= '0;
      cs_evn_n   <= '1;
      cs_odd_n   <= '1;
      dtack_n    <= 1'b1;
      berr_n     <= 1'b1;
      cycle_busy <= 1'b0;
    end else begin
      state_q    <= state_d;
      wcnt_q     <= wcnt_d;
      tcnt_q     <= tcnt_d;
      armed_q    <= armed_d;
      region     <= region_d;
      cs_evn_n   <= cs_evn_d;
      cs_odd_n   <= cs_odd_d;
      dtack_n    <= dtack_d;
      berr_n     <= berr_d;
      cycle_busy <= busy_d;
    end
  end

endmodule

// File: tb/tb_bus_cycle_ctrl.sv
// Scoreboard bench for bus_cycle_ctrl: per-clock expected outputs are queued as
// stimulus is driven and compared one clock later after the active edge.
module tb_bus_cycle_ctrl;

  localparam int unsigned ADDR_W  = 24;
  localparam int unsigned NREG    = 4;
  localparam int unsigned WAIT_W  = 4;
  localparam int unsigned TIMEOUT = 16;
  localparam int unsigned TO_W    = 5;
  localparam int          W1      = 3;
  localparam int          T       = 16;

  localparam logic [NREG*ADDR_W-1:0] BASE = {24'h000000, 24'h200000, 24'h100000, 24'h000000};
  localparam logic [NREG*ADDR_W-1:0] MASK = {24'h800000, 24'hF00000, 24'hF00000, 24'hF00000};
  localparam logic [NREG*WAIT_W-1:0] WAITS = {4'd0, 4'd0, 4'd3, 4'd0};
  localparam logic [NREG-1:0]        EXTS  = 4'b0100;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic [ADDR_W-1:0] addr = '0;
  logic              as_n = 1'b1, uds_n = 1'b1, lds_n = 1'b1, ext_dtack_n = 1'b1;
  logic [NREG-1:0]   cs_evn_n, cs_odd_n;
  logic              dtack_n, berr_n, cycle_busy;
  logic [2:0]        region;

  typedef struct {
    string       tag;
    logic [13:0] v;
    logic        chk_rgn;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  bus_cycle_ctrl #(
    .ADDR_W(ADDR_W), .NREG(NREG), .REG_BASE(BASE), .REG_MASK(MASK),
    .WAIT_W(WAIT_W), .REG_WAIT(WAITS), .REG_EXT(EXTS),
    .TIMEOUT(TIMEOUT), .TO_W(TO_W)
  ) dut (
    .clk(clk), .reset(reset), .addr(addr), .as_n(as_n), .uds_n(uds_n),
    .lds_n(lds_n), .ext_dtack_n(ext_dtack_n), .cs_evn_n(cs_evn_n),
    .cs_odd_n(cs_odd_n), .dtack_n(dtack_n), .berr_n(berr_n),
    .cycle_busy(cycle_busy), .region(region)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [13:0] got, input logic [13:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  function automatic logic [3:0] cs1(input int r);
    logic [3:0] m;
    m    = 4'hF;
    m[r] = 1'b0;
    return m;
  endfunction

  // Drive one clock of stimulus and queue the outputs expected after that edge
  task automatic step(input logic r, input logic a, input logic [ADDR_W-1:0] adr,
                      input logic u, input logic l, input logic x, input string tag,
                      input logic [3:0] ee, input logic [3:0] eo, input logic dt,
                      input logic be, input logic bz, input logic [2:0] rg,
                      input logic cr);
    exp_t e;
    @(negedge clk);
    reset = r; as_n = a; addr = adr; uds_n = u; lds_n = l; ext_dtack_n = x;
    e.tag = tag;
    e.v = {ee, eo, dt, be, bz, (cr ? rg : 3'd0)};
    e.chk_rgn = cr;
    sb.push_back(e);
  endtask

  task automatic idle(input string tag, input logic a);
    step(1'b0, a, 24'h0, 1'b1, 1'b1, 1'b1, tag, 4'hF, 4'hF, 1'b1, 1'b1, 1'b0, 3'd0, 1'b0);
  endtask

  // Monitor: compare each queued expectation just after its edge
  initial begin
    exp_t        e;
    logic [13:0] got;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e   = sb.pop_front();
        got = {cs_evn_n, cs_odd_n, dtack_n, berr_n, cycle_busy, (e.chk_rgn ? region : 3'd0)};
        check(e.tag, got, e.v);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    // Reset and arm
    repeat (2) step(1'b1, 1'b1, 24'h0, 1'b1, 1'b1, 1'b1, "reset", 4'hF, 4'hF, 1'b1, 1'b1, 1'b0, 3'd0, 1'b0);
    repeat (2) idle("idle_post_reset", 1'b1);

    // Internal acknowledge, zero wait, region 0 (region 3 also matches)
    step(0, 0, 24'h000100, 0, 0, 1, "a_start", 4'hF, 4'hF, 1, 1, 1, 3'd0, 1);
    for (int k = 1; k <= 2; k++)
      step(0, 0, 24'h000100, 0, 0, 1, "a_ack", cs1(0), cs1(0), 0, 1, 1, 3'd0, 1);
    step(0, 1, 24'h000100, 1, 1, 1, "a_release", 4'hF, 4'hF, 1, 1, 0, 3'd0, 0);
    idle("a_idle", 1'b1);

    // Three wait states, lds_n first then a late uds_n
    step(0, 0, 24'h100000, 1, 0, 1, "b_start", 4'hF, 4'hF, 1, 1, 1, 3'd1, 1);
    for (int k = 1; k <= 5; k++)
      step(0, 0, 24'h100000, (k >= 2) ? 1'b0 : 1'b1, 0, 1, "b_wait",
           (k >= 2) ? cs1(1) : 4'hF, cs1(1), (k >= W1 + 1) ? 1'b0 : 1'b1, 1, 1, 3'd1, 1);
    step(0, 1, 24'h100000, 1, 1, 1, "b_release", 4'hF, 4'hF, 1, 1, 0, 3'd0, 0);
    idle("b_idle", 1'b1);

    // External acknowledge after 10 clocks
    step(0, 0, 24'h200000, 0, 0, 1, "c_start", 4'hF, 4'hF, 1, 1, 1, 3'd2, 1);
    for (int k = 1; k <= 12; k++)
      step(0, 0, 24'h200000, 0, 0, (k >= 10) ? 1'b0 : 1'b1, "c_ext",
           cs1(2), cs1(2), (k >= 11) ? 1'b0 : 1'b1, 1, 1, 3'd2, 1);
    step(0, 1, 24'h200000, 1, 1, 1, "c_release", 4'hF, 4'hF, 1, 1, 0, 3'd0, 0);
    idle("c_idle", 1'b1);

    // External acknowledge on the timeout clock: acknowledge wins
    step(0, 0, 24'h200000, 0, 0, 1, "c2_start", 4'hF, 4'hF, 1, 1, 1, 3'd2, 1);
    for (int k = 1; k <= T + 1; k++)
      step(0, 0, 24'h200000, 0, 0, (k >= T - 1) ? 1'b0 : 1'b1, "c2_race",
           cs1(2), cs1(2), (k >= T) ? 1'b0 : 1'b1, 1, 1, 3'd2, 1);
    step(0, 1, 24'h200000, 1, 1, 1, "c2_release", 4'hF, 4'hF, 1, 1, 0, 3'd0, 0);
    idle("c2_idle", 1'b1);

    // External acknowledge never arrives: bus error
    step(0, 0, 24'h200000, 0, 0, 1, "c3_start", 4'hF, 4'hF, 1, 1, 1, 3'd2, 1);
    for (int k = 1; k <= T + 1; k++)
      step(0, 0, 24'h200000, 0, 0, 1, "c3_timeout",
           (k < T) ? cs1(2) : 4'hF, (k < T) ? cs1(2) : 4'hF, 1, (k >= T) ? 1'b0 : 1'b1, 1, 3'd2, 1);
    step(0, 1, 24'h200000, 1, 1, 1, "c3_release", 4'hF, 4'hF, 1, 1, 0, 3'd0, 0);
    idle("c3_idle", 1'b1);

    // Unmapped address
    step(0, 0, 24'hF00000, 0, 0, 1, "d_start", 4'hF, 4'hF, 1, 1, 1, 3'd0, 0);
    for (int k = 1; k <= T + 2; k++)
      step(0, 0, 24'hF00000, 0, 0, 1, "d_unmap", 4'hF, 4'hF, 1, (k >= T) ? 1'b0 : 1'b1, 1, 3'd0, 0);
    step(0, 1, 24'hF00000, 1, 1, 1, "d_release", 4'hF, 4'hF, 1, 1, 0, 3'd0, 0);
    idle("d_idle", 1'b1);

    // Region 3 alone
    step(0, 0, 24'h400000, 0, 0, 1, "e_start", 4'hF, 4'hF, 1, 1, 1, 3'd3, 1);
    step(0, 0, 24'h400000, 0, 0, 1, "e_ack", cs1(3), cs1(3), 0, 1, 1, 3'd3, 1);
    step(0, 1, 24'h400000, 1, 1, 1, "e_release", 4'hF, 4'hF, 1, 1, 0, 3'd0, 0);
    idle("e_idle", 1'b1);

    // Abort during wait states; as_n low again without a high sample is ignored
    step(0, 0, 24'h100000, 0, 0, 1, "f_start", 4'hF, 4'hF, 1, 1, 1, 3'd1, 1);
    step(0, 0, 24'h100000, 0, 0, 1, "f_wait", cs1(1), cs1(1), 1, 1, 1, 3'd1, 1);
    step(0, 1, 24'h100000, 0, 0, 1, "f_abort", 4'hF, 4'hF, 1, 1, 0, 3'd0, 0);
    repeat (2) step(0, 0, 24'h100000, 0, 0, 1, "f_no_rearm", 4'hF, 4'hF, 1, 1, 0, 3'd0, 0);
    idle("f_arm", 1'b1);
    step(0, 0, 24'h100000, 0, 0, 1, "f_restart", 4'hF, 4'hF, 1, 1, 1, 3'd1, 1);
    step(0, 0, 24'h100000, 0, 0, 1, "f_rewait", cs1(1), cs1(1), 1, 1, 1, 3'd1, 1);
    step(0, 1, 24'h100000, 1, 1, 1, "f_abort2", 4'hF, 4'hF, 1, 1, 0, 3'd0, 0);
    idle("f_idle", 1'b1);

    // Reset mid-cycle
    step(0, 0, 24'h100000, 0, 0, 1, "g_start", 4'hF, 4'hF, 1, 1, 1, 3'd1, 1);
    step(0, 0, 24'h100000, 0, 0, 1, "g_wait", cs1(1), cs1(1), 1, 1, 1, 3'd1, 1);
    step(1, 0, 24'h100000, 0, 0, 1, "g_reset", 4'hF, 4'hF, 1, 1, 0, 3'd0, 0);
    repeat (2) idle("g_idle", 1'b1);

    repeat (3) @(negedge clk);
    check("sb_drain", 14'(sb.size()), 14'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
